// File: rtl/im_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_boot_loader
// Brief    : Packs a byte stream into little-endian 32-bit words and writes
//            them into instruction SRAM, holding the core in reset until the
//            image has been loaded. Optional macro: IM_BOOT_LOADER_CKSUM_EN
//            (the last byte becomes an additive checksum of the payload).
// Revision : 1.0 - initial release
// ============================================================================
module im_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        in_ready,
  output logic [3:0]  im_w_en,
  output logic [15:0] im_address,
  output logic [31:0] im_write_data,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_error,
  output logic [14:0] word_count
);

  localparam logic [14:0] c_MAX_WORDS = 15'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_in_ready;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_buf;
  logic        r_last_pending;
  logic [14:0] r_word_count;
  logic        w_accept;
  logic        w_overflow;
  logic        w_store;

`ifdef IM_BOOT_LOADER_CKSUM_EN
  logic [7:0]  r_sum;
  logic [7:0]  r_cksum;
`endif

  assign w_accept   = in_valid & r_in_ready;
  assign w_overflow = (r_word_count == c_MAX_WORDS);

  always_comb begin
    w_next  = r_state;
    w_store = 1'b0;
    unique case (r_state)
      ST_RECV: begin
        if (w_accept) begin
          if (w_overflow) begin
            w_next = ST_ERROR;
          end else begin
`ifdef IM_BOOT_LOADER_CKSUM_EN
            // The checksum byte is never stored; a pending partial word is
            // flushed first and the comparison happens after its write.
            if (in_last) begin
              if (r_byte_idx != 2'd0) begin
                w_next = ST_WRITE;
              end else begin
                w_next = (r_sum == in_byte) ? ST_DONE : ST_ERROR;
              end
            end else begin
              w_store = 1'b1;
              if (r_byte_idx == 2'd3) begin
                w_next = ST_WRITE;
              end
            end
`else
            w_store = 1'b1;
            if (in_last || (r_byte_idx == 2'd3)) begin
              w_next = ST_WRITE;
            end
`endif
          end
        end
      end
      ST_WRITE: begin
`ifdef IM_BOOT_LOADER_CKSUM_EN
        if (r_last_pending) begin
          w_next = (r_sum == r_cksum) ? ST_DONE : ST_ERROR;
        end else begin
          w_next = ST_RECV;
        end
`else
        w_next = r_last_pending ? ST_DONE : ST_RECV;
`endif
      end
      ST_DONE:  w_next = ST_DONE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RECV;
      r_in_ready     <= 1'b0;
      r_byte_idx     <= 2'd0;
      r_buf          <= 32'h0;
      r_last_pending <= 1'b0;
      r_word_count   <= 15'd0;
    end else begin
      r_state    <= w_next;
      // Ready is only ever offered while the next state is RECV, so an
      // accepted byte always belongs to the RECV state.
      r_in_ready <= (w_next == ST_RECV);
      if (w_store) begin
        r_buf[{r_byte_idx, 3'b000} +: 8] <= in_byte;
        r_byte_idx                       <= r_byte_idx + 2'd1;
      end
      if (w_accept) begin
        r_last_pending <= in_last;
      end
      if (r_state == ST_WRITE) begin
        r_word_count <= r_word_count + 15'd1;
        r_buf        <= 32'h0;
        r_byte_idx   <= 2'd0;
      end
    end
  end

`ifdef IM_BOOT_LOADER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= 8'h00;
      r_cksum <= 8'h00;
    end else begin
      if (w_store) begin
        r_sum <= r_sum + in_byte;
      end
      if (w_accept && in_last) begin
        r_cksum <= in_byte;
      end
    end
  end
`endif

  assign in_ready      = r_in_ready;
  assign im_w_en       = (r_state == ST_WRITE) ? 4'hF : 4'h0;
  assign im_address    = BASE_ADDR + 16'({r_word_count, 2'b00});
  assign im_write_data = r_buf;
  assign core_rst      = (r_state != ST_DONE);
  assign load_done     = (r_state == ST_DONE);
  assign load_error    = (r_state == ST_ERROR);
  assign word_count    = r_word_count;

endmodule
`default_nettype wire
